// File: rtl/gray_sync_decode.sv
// Synchronises a gray-coded word from another clock domain, decodes it to binary,
// and reports each change with its modular step size plus a sticky multi-bit-change flag.
module gray_sync_decode #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             err_clr,
   output logic [WIDTH-1:0] bin_out,
   output logic             changed,
   output logic [WIDTH-1:0] delta,
   output logic             err
);

   typedef enum logic {
      ST_INIT,
      ST_TRACK
   } state_t;

   localparam int                FILL_W    = $clog2(SYNC_STAGES + 1);
   localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [SYNC_STAGES-1:0][WIDTH-1:0] s_q, s_d;
   state_t                            state_q, state_d;
   logic [FILL_W-1:0]                 fill_q, fill_d;
   logic [WIDTH-1:0]                  bin_q, bin_d;
   logic [WIDTH-1:0]                  g_prev_q, g_prev_d;
   logic                              changed_q, changed_d;
   logic [WIDTH-1:0]                  delta_q, delta_d;
   logic                              err_q, err_d;

   logic [WIDTH-1:0] g_s;
   logic [WIDTH-1:0] bin_s;
   logic [WIDTH-1:0] g_diff;
   logic             multi_bit;

   // Pure shift chain: no logic may sit between the synchroniser flops.
   always_comb begin
      s_d = {s_q[SYNC_STAGES-2:0], gray_in};
   end

   assign g_s    = s_q[SYNC_STAGES-1];
   assign bin_s  = gray2bin(g_s);
   assign g_diff = g_s ^ g_prev_q;
   // Clearing the lowest set bit leaves something only if two or more bits moved.
   assign multi_bit = |(g_diff & (g_diff - WIDTH'(1)));

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      bin_d     = bin_q;
      g_prev_d  = g_prev_q;
      changed_d = changed_q;
      delta_d   = delta_q;
      err_d     = err_q;

      unique case (state_q)
         ST_INIT: begin
            if (fill_q == FILL_DONE) begin
               bin_d    = bin_s;
               g_prev_d = g_s;
               state_d  = ST_TRACK;
            end else begin
               fill_d = fill_q + FILL_W'(1);
            end
         end
         ST_TRACK: begin
            if (g_diff != '0) begin
               bin_d     = bin_s;
               delta_d   = bin_s - bin_q;
               changed_d = 1'b1;
               g_prev_d  = g_s;
            end else begin
               changed_d = 1'b0;
               delta_d   = '0;
            end
            // A fresh detection beats a simultaneous clear.
            if (multi_bit) begin
               err_d = 1'b1;
            end else if (err_clr) begin
               err_d = 1'b0;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q       <= '0;
         state_q   <= ST_INIT;
         fill_q    <= '0;
         bin_q     <= '0;
         g_prev_q  <= '0;
         changed_q <= 1'b0;
         delta_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         s_q       <= s_d;
         state_q   <= state_d;
         fill_q    <= fill_d;
         bin_q     <= bin_d;
         g_prev_q  <= g_prev_d;
         changed_q <= changed_d;
         delta_q   <= delta_d;
         err_q     <= err_d;
      end
   end

   assign bin_out = bin_q;
   assign changed = changed_q;
   assign delta   = delta_q;
   assign err     = err_q;

endmodule

// File: tb/tb_gray_sync_decode.sv
// Directed and randomized bench for gray_sync_decode, checked against a cycle-level
// reference model built from gray-code arithmetic and a history of sampled inputs.
module tb_gray_sync_decode;

   localparam int W = 4;
   localparam int S = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] gray_in = '0;
   logic         err_clr = 1'b0;
   logic [W-1:0] bin_out;
   logic         changed;
   logic [W-1:0] delta;
   logic         err;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int n_edges;
   int hist[$];
   int m_bin, m_prev, m_delta;
   int m_changed, m_err;

   gray_sync_decode #(.WIDTH(W), .SYNC_STAGES(S)) dut (
      .clk     (clk),
      .rst     (rst),
      .gray_in (gray_in),
      .err_clr (err_clr),
      .bin_out (bin_out),
      .changed (changed),
      .delta   (delta),
      .err     (err)
   );

   always #5 clk = ~clk;

   // Binary value is the index whose gray code i^(i>>1) equals g.
   function automatic int to_bin(int g);
      for (int i = 0; i < (1 << W); i++) begin
         if ((i ^ (i >> 1)) == g) return i;
      end
      return -1;
   endfunction

   function automatic int to_gray(int b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      n_edges   = 0;
      hist.delete();
      m_bin     = 0;
      m_prev    = 0;
      m_delta   = 0;
      m_changed = 0;
      m_err     = 0;
   endtask

   task automatic model_edge();
      int g;
      int nb;
      hist.push_back(int'(gray_in));
      n_edges++;
      g = (n_edges > S) ? hist[n_edges-1-S] : 0;
      if (n_edges == S + 1) begin
         m_bin  = to_bin(g);
         m_prev = g;
      end else if (n_edges > S + 1) begin
         if ($countones(g ^ m_prev) > 1) m_err = 1;
         else if (err_clr) m_err = 0;
         if (g != m_prev) begin
            nb        = to_bin(g);
            m_delta   = (nb - m_bin) & ((1 << W) - 1);
            m_bin     = nb;
            m_changed = 1;
            m_prev    = g;
         end else begin
            m_changed = 0;
            m_delta   = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".bin_out"}, 32'(bin_out), 32'(m_bin));
      check({tag, ".changed"}, 32'(changed), 32'(m_changed));
      check({tag, ".delta"},   32'(delta),   32'(m_delta));
      check({tag, ".err"},     32'(err),     32'(m_err));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic assert_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
   endtask

   task automatic release_reset();
      step("in_reset");
      rst = 1'b0;
   endtask

   int seq2[3] = '{1, 3, 2};

   initial begin
      model_reset();

      // 1: zero input through reset and 20 cycles
      gray_in = '0;
      assert_reset("t1_reset");
      release_reset();
      repeat (20) step("t1_idle");
      check("t1_bin_zero", 32'(bin_out), 32'd0);

      // 2: gray 0001, 0011, 0010 -> bin 1, 2, 3 on consecutive cycles
      for (int i = 0; i < 5; i++) begin
         if (i < 3) gray_in = W'(seq2[i]);
         step("t2");
         if (i >= 2) begin
            check("t2_bin", 32'(bin_out), 32'(i - 1));
            check("t2_changed", 32'(changed), 32'd1);
            check("t2_delta", 32'(delta), 32'd1);
         end
      end

      // 3: legal walk up to bin 15, then wrap to 0
      for (int b = 4; b < 16; b++) begin
         gray_in = W'(to_gray(b));
         step("t3_walk");
      end
      repeat (2) step("t3_settle");
      check("t3_bin15", 32'(bin_out), 32'd15);
      gray_in = 4'b0000;
      repeat (3) step("t3_wrap");
      check("t3_wrap_bin", 32'(bin_out), 32'd0);
      check("t3_wrap_changed", 32'(changed), 32'd1);
      check("t3_wrap_delta", 32'(delta), 32'd1);
      check("t3_wrap_err", 32'(err), 32'd0);

      // 4: illegal jump 0000 -> 0011, then clear
      gray_in = 4'b0011;
      repeat (3) step("t4_jump");
      check("t4_bin", 32'(bin_out), 32'd2);
      check("t4_delta", 32'(delta), 32'd2);
      check("t4_changed", 32'(changed), 32'd1);
      check("t4_err", 32'(err), 32'd1);
      repeat (3) step("t4_hold");
      check("t4_err_sticky", 32'(err), 32'd1);
      err_clr = 1'b1;
      step("t4_clr");
      err_clr = 1'b0;
      check("t4_err_cleared", 32'(err), 32'd0);

      // 5: err_clr coincides with a new multi-bit change reaching decode
      gray_in = 4'b0000;
      repeat (3) step("t5_back");
      err_clr = 1'b1;
      step("t5_preclr");
      err_clr = 1'b0;
      check("t5_err_pre", 32'(err), 32'd0);
      gray_in = 4'b0101;
      repeat (2) step("t5_sync");
      err_clr = 1'b1;
      step("t5_collide");
      err_clr = 1'b0;
      check("t5_err_set_wins", 32'(err), 32'd1);
      check("t5_bin", 32'(bin_out), 32'd6);

      // 6: reset mid-stream at bin 9, release with gray 0101
      for (int b = 7; b <= 9; b++) begin
         gray_in = W'(to_gray(b));
         step("t6_walk");
      end
      repeat (2) step("t6_settle");
      check("t6_bin9", 32'(bin_out), 32'd9);
      gray_in = 4'b0101;
      assert_reset("t6_reset");
      check("t6_bin_zero", 32'(bin_out), 32'd0);
      check("t6_err_zero", 32'(err), 32'd0);
      release_reset();
      repeat (2) step("t6_fill");
      check("t6_bin_not_yet", 32'(bin_out), 32'd0);
      step("t6_load");
      check("t6_bin6", 32'(bin_out), 32'd6);
      check("t6_no_changed", 32'(changed), 32'd0);
      check("t6_err0", 32'(err), 32'd0);

      // Randomized walk: mostly legal steps, some holds, some illegal jumps, one reset
      for (int c = 0; c < 400; c++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 6) gray_in = gray_in ^ W'(1 << $urandom_range(0, W - 1));
         else if (r == 9) gray_in = W'($urandom_range(0, (1 << W) - 1));
         err_clr = ($urandom_range(0, 7) == 0);
         if (c == 200) begin
            assert_reset("rnd_reset");
            release_reset();
         end
         step("rnd");
      end
      err_clr = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
